// File: rtl/shift_sequencer_pkg.sv
// Shared constants for shift_sequencer: widths, op codes and FSM state encoding.
package shift_sequencer_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'd0;
    localparam logic [OP_W-1:0] OP_ROL = 3'd1;
    localparam logic [OP_W-1:0] OP_SRL = 3'd2;
    localparam logic [OP_W-1:0] OP_SRA = 3'd3;
    localparam logic [OP_W-1:0] OP_ROR = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Codes above OP_ROR are pass-through and never enter SHIFT.
    function automatic logic op_is_shift(input logic [OP_W-1:0] op);
        return op <= OP_ROR;
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// shift_step: combinational one-position shift/rotate of a value by the given op.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned DataWidth = DATA_W
) (
    input  logic [DataWidth-1:0] value_i,
    input  logic [OP_W-1:0]      op_i,
    output logic [DataWidth-1:0] value_o
);

    always_comb begin
        value_o = value_i;
        case (op_i)
            OP_SLL:  value_o = {value_i[DataWidth-2:0], 1'b0};
            OP_ROL:  value_o = {value_i[DataWidth-2:0], value_i[DataWidth-1]};
            OP_SRL:  value_o = {1'b0, value_i[DataWidth-1:1]};
            OP_SRA:  value_o = {value_i[DataWidth-1], value_i[DataWidth-1:1]};
            OP_ROR:  value_o = {value_i[0], value_i[DataWidth-1:1]};
            default: value_o = value_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: one position per SHIFT cycle, or two when
// SHIFT_SEQ_DOUBLE_STEP_EN is defined.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned ShamtWidth = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [DataWidth-1:0]  DataA,
    input  logic [ShamtWidth-1:0] ShiftAmount,
    input  logic [OP_W-1:0]       ShiftOp,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DataWidth-1:0]  Result,
    output logic                  Busy
);

    state_e                state_q;
    logic [DataWidth-1:0]  work_q, work_d;
    logic [ShamtWidth-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]       op_q;
    logic                  last_step;
    logic [DataWidth-1:0]  step1;

    shift_step #(.DataWidth(DataWidth)) u_step0 (
        .value_i (work_q),
        .op_i    (op_q),
        .value_o (step1)
    );

`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
    logic [DataWidth-1:0] step2;

    shift_step #(.DataWidth(DataWidth)) u_step1 (
        .value_i (step1),
        .op_i    (op_q),
        .value_o (step2)
    );

    always_comb begin
        if (cnt_q >= ShamtWidth'(2)) begin
            work_d = step2;
            cnt_d  = cnt_q - ShamtWidth'(2);
        end else begin
            work_d = step1;
            cnt_d  = cnt_q - ShamtWidth'(1);
        end
        last_step = (cnt_q <= ShamtWidth'(2));
    end
`else
    always_comb begin
        work_d    = step1;
        cnt_d     = cnt_q - ShamtWidth'(1);
        last_step = (cnt_q <= ShamtWidth'(1));
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            op_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (InValid) begin
                        work_q  <= DataA;
                        cnt_q   <= ShiftAmount;
                        op_q    <= ShiftOp;
                        state_q <= (ShiftAmount == '0 || !op_is_shift(ShiftOp)) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_d;
                    if (last_step) state_q <= DONE;
                end
                DONE: begin
                    if (OutReady) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == DONE);
    assign Busy     = (state_q != IDLE);
    assign Result   = work_q;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter DataWidth, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have parameter ShamtWidth, default 5, shift-amount width; SHALL equal log2(DataWidth).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Clock  input  1  rising-edge system clock.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 InValid  input  1  request present.
REQ-007 InReady  output  1  sequencer can accept a request.
REQ-008 DataA  input  32  operand.
REQ-009 ShiftAmount  input  5  number of positions.
REQ-010 ShiftOp  input  3  operation: 0 SLL, 1 ROL, 2 SRL, 3 SRA, 4 ROR.
REQ-011 OutValid  output  1  Result is valid.
REQ-012 OutReady  input  1  consumer accepts Result.
REQ-013 Result  output  32  shifted value.
REQ-014 Busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-016 InReady SHALL be 1 only in IDLE, which makes it a combinational decode of the state register.
REQ-017 Accept SHALL occur when InValid && InReady; on accept, DataA, ShiftAmount and ShiftOp SHALL be latched into a work register, a down-counter and an op register.
REQ-018 The accept transition SHALL go to DONE if ShiftAmount==0 or ShiftOp is 5..7; otherwise it SHALL go to SHIFT.
REQ-019 In SHIFT, each cycle SHALL apply a one-position step of the latched op to the work register and decrement the counter; when the counter reaches 1 the state SHALL go to DONE.
REQ-020 SRA steps SHALL replicate bit 31. SLL and SRL steps SHALL insert 0. ROL/ROR steps SHALL move the outgoing bit to the opposite end.
REQ-021 Latency SHALL be N+1 cycles from the accept edge to OutValid=1, for amount N (N=0 gives 1 cycle).
REQ-022 In DONE, OutValid SHALL be 1 and Result SHALL equal the work register, held stable until OutReady=1.
REQ-023 When OutValid && OutReady, the state SHALL go to IDLE; there is no same-cycle re-accept, so the minimum spacing between requests is N+2 cycles.
REQ-024 Result SHALL equal the work register in all states; OutValid SHALL be 0 outside DONE.
REQ-025 Input changes while Busy SHALL be ignored.
REQ-026 Op codes 5..7 SHALL return DataA unchanged.

Reset
REQ-027 Reset SHALL force IDLE, counter=0, work register=0, op register=0.
REQ-028 After reset: InReady=1, OutValid=0, Busy=0, Result=0.
REQ-029 Reset SHALL override all other inputs in the same cycle; an in-flight operation SHALL be discarded with no OutValid pulse.

Configuration
REQ-030 SHIFT_SEQ_DOUBLE_STEP_EN, when defined, SHALL make SHIFT apply two positions per cycle while counter>=2 (decrement by 2), and one position otherwise.
REQ-031 With the macro defined, latency SHALL be ceil(N/2)+1.
REQ-032 Without the macro, only single-position stepping SHALL exist, with latency per REQ-021, and the double-step logic SHALL NOT be synthesized.

Structure
REQ-033 A shared package SHALL hold the op encoding constants (OP_SLL..OP_ROR), the state encoding (IDLE=0, SHIFT=1, DONE=2), and the width constants.
REQ-034 A combinational sub-module shift_step SHALL compute the one-position step (inputs: value, op; output: stepped value).
REQ-035 The double-step path SHALL instantiate shift_step twice in series.

Verification
REQ-036 SLL of 0x00000001 by 31 SHALL give Result 0x80000000, with OutValid rising 32 cycles after accept (16+1=17 with the macro).
REQ-037 SRA of 0x80000000 by 4 SHALL give 0xF8000000; SRL of the same operand and amount SHALL give 0x08000000.
REQ-038 ROR of 0x00000001 by 1 SHALL give 0x80000000 after 2 cycles; ROL of 0x80000000 by 1 SHALL give 0x00000001.
REQ-039 SRL of 0x12345678 by 0, and op 6 with any amount, SHALL each give 0x12345678 after 1 cycle.
REQ-040 With OutReady held 0 for 5 cycles in DONE, Result SHALL stay stable, InReady SHALL stay 0, and a new InValid SHALL be ignored; after OutReady=1, IDLE SHALL follow next cycle.
REQ-041 Reset asserted 3 cycles into a 20-position shift SHALL give IDLE, Result=0, and OutValid never asserted; a following request SHALL complete correctly.
